// File: rtl/periph_bus_arbiter.sv
// Data-side address decoder and read-return arbiter: CPU data port to data
// memory, NPERIPH 16-byte peripheral slots and a small error-status block.
module periph_bus_arbiter #(
  parameter int unsigned NPERIPH     = 4,
  parameter logic [31:0] PERIPH_BASE = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 dvalid,
  input  logic [31:0]          daddr,
  input  logic [3:0]           dwe,
  input  logic [31:0]          dwdata,
  output logic [31:0]          drdata,
  output logic [3:0]           dmem_we,
  input  logic [31:0]          dmem_rdata,
  output logic [NPERIPH-1:0]   periph_ce,
  output logic                 periph_we,
  output logic [1:0]           periph_addr,
  output logic [31:0]          periph_wdata,
  input  logic [32*NPERIPH-1:0] periph_rdata
);

  typedef enum logic [1:0] {SelNone, SelMem, SelPeriph, SelStatus} sel_e;

  sel_e        r_sel_q, w_sel_d;
  logic [3:0]  r_sel_idx_q;
  logic [15:0] r_err_count;
  logic [31:0] r_last_err_addr;
  logic [31:0] r_stat_data;

  logic        w_win, w_status, w_phit, w_unmapped, w_write, w_partial;
  logic        w_err, w_ce_en, w_clear, w_stat_rd;
  logic [3:0]  w_idx;
  logic [31:0] w_stat_next;
  logic [31:0] w_periph_sel;

  // Address decode and error classification, all qualified by dvalid.
  always_comb begin
    w_win      = (daddr[31:12] == PERIPH_BASE[31:12]);
    w_idx      = daddr[7:4];
    w_status   = w_win && (daddr[11:4] == 8'hFF);
    w_phit     = w_win && (daddr[11:8] == 4'h0) && (32'(w_idx) < NPERIPH);
    w_unmapped = w_win && !w_status && !w_phit;
    w_write    = (dwe != 4'b0000);
    w_partial  = w_phit && w_write && (dwe != 4'b1111);
    w_err      = dvalid && (w_unmapped || w_partial);
    w_ce_en    = dvalid && w_phit && !w_partial;
    // Only a write to the count register clears; +0xFF4..+0xFFC writes are dropped.
    w_clear    = dvalid && w_status && w_write && (daddr[3:2] == 2'b00);
    w_stat_rd  = dvalid && w_status && !w_write;
  end

  // Combinational bus outputs toward memory and peripherals.
  always_comb begin
    periph_ce = '0;
    for (int unsigned k = 0; k < NPERIPH; k++) begin
      periph_ce[k] = w_ce_en && (w_idx == 4'(k));
    end
    periph_we    = w_ce_en && (dwe == 4'b1111);
    periph_addr  = daddr[3:2];
    periph_wdata = dwdata;
    dmem_we      = (dvalid && !w_win) ? dwe : 4'b0000;
  end

  // Next return-select and status read data.
  always_comb begin
    w_sel_d = SelNone;
    if (dvalid && !w_write) begin
      if (!w_win)        w_sel_d = SelMem;
      else if (w_status) w_sel_d = SelStatus;
      else if (w_phit)   w_sel_d = SelPeriph;
    end
    unique case (daddr[3:2])
      2'b00:   w_stat_next = {16'b0, r_err_count};
      2'b01:   w_stat_next = r_last_err_addr;
      default: w_stat_next = 32'b0;
    endcase
  end

  // Return-select register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_q     <= SelNone;
      r_sel_idx_q <= 4'b0;
    end else begin
      r_sel_q     <= w_sel_d;
      r_sel_idx_q <= w_idx;
    end
  end

  // Error counter (saturating), last error address and status read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count     <= 16'b0;
      r_last_err_addr <= 32'b0;
      r_stat_data     <= 32'b0;
    end else begin
      if (w_clear) begin
        r_err_count     <= 16'b0;
        r_last_err_addr <= 32'b0;
      end else if (w_err) begin
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        r_last_err_addr <= daddr;
      end
      if (w_stat_rd) r_stat_data <= w_stat_next;
    end
  end

  // Read-data return mux driven by last cycle's select.
  always_comb begin
    w_periph_sel = 32'b0;
    for (int unsigned k = 0; k < NPERIPH; k++) begin
      if (r_sel_idx_q == 4'(k)) w_periph_sel = periph_rdata[32*k +: 32];
    end
    unique case (r_sel_q)
      SelMem:    drdata = dmem_rdata;
      SelPeriph: drdata = w_periph_sel;
      SelStatus: drdata = r_stat_data;
      default:   drdata = 32'b0;
    endcase
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter with a read-return scoreboard queue.
module tb_periph_bus_arbiter;

  localparam int unsigned NP = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SLOT0 = 32'h1111_0000;
  localparam logic [31:0] SLOT1 = 32'h0000_1234;
  localparam logic [31:0] SLOT2 = 32'h2222_2222;
  localparam logic [31:0] SLOT3 = 32'h3333_3333;
  localparam logic [31:0] MEMD  = 32'h0000_00AA;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dvalid;
  logic [31:0]   daddr;
  logic [3:0]    dwe;
  logic [31:0]   dwdata;
  logic [31:0]   drdata;
  logic [3:0]    dmem_we;
  logic [31:0]   dmem_rdata;
  logic [NP-1:0] periph_ce;
  logic          periph_we;
  logic [1:0]    periph_addr;
  logic [31:0]   periph_wdata;
  logic [32*NP-1:0] periph_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  periph_bus_arbiter #(.NPERIPH(NP), .PERIPH_BASE(BASE)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dvalid       (dvalid),
    .daddr        (daddr),
    .dwe          (dwe),
    .dwdata       (dwdata),
    .drdata       (drdata),
    .dmem_we      (dmem_we),
    .dmem_rdata   (dmem_rdata),
    .periph_ce    (periph_ce),
    .periph_we    (periph_we),
    .periph_addr  (periph_addr),
    .periph_wdata (periph_wdata),
    .periph_rdata (periph_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one access for the coming cycle and queue its expected return data.
  task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] we,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
    dvalid = v;
    daddr  = a;
    dwe    = we;
    dwdata = wd;
    exp_q.push_back(exp_rd);
  endtask

  // Close the cycle and compare the returned read data against the scoreboard.
  task automatic step(input string tag);
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, drdata, e);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    dvalid       = 1'b0;
    daddr        = 32'b0;
    dwe          = 4'b0;
    dwdata       = 32'b0;
    dmem_rdata   = MEMD;
    periph_rdata = {SLOT3, SLOT2, SLOT1, SLOT0};

    repeat (2) @(posedge clk);
    #2;
    check("rst_drdata", drdata, 32'b0);
    check("rst_dmem_we", {28'b0, dmem_we}, 32'b0);
    check("rst_ce", {28'b0, periph_ce}, 32'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-word peripheral write to slot 1, register 1.
    drive(1'b1, BASE + 32'h14, 4'b1111, 32'd5, 32'b0);
    #1;
    check("wr_ce", {28'b0, periph_ce}, 32'h2);
    check("wr_we", {31'b0, periph_we}, 32'h1);
    check("wr_addr", {30'b0, periph_addr}, 32'h1);
    check("wr_dmem_we", {28'b0, dmem_we}, 32'h0);
    check("wr_wdata", periph_wdata, 32'd5);
    step("wr_ret");

    // Back-to-back reads: peripheral slot 1, then memory.
    drive(1'b1, BASE + 32'h18, 4'b0000, 32'b0, SLOT1);
    #1;
    check("rdp_ce", {28'b0, periph_ce}, 32'h2);
    check("rdp_we", {31'b0, periph_we}, 32'h0);
    step("rdp_ret");
    drive(1'b1, 32'h0000_0100, 4'b0000, 32'b0, MEMD);
    #1;
    check("rdm_ce", {28'b0, periph_ce}, 32'h0);
    step("rdm_ret");

    // Memory byte write passes strobes through.
    drive(1'b1, 32'h0000_0200, 4'b0101, 32'hDEAD_BEEF, 32'b0);
    #1;
    check("mwr_dmem_we", {28'b0, dmem_we}, 32'h5);
    check("mwr_ce", {28'b0, periph_ce}, 32'h0);
    step("mwr_ret");

    // Partial-word peripheral write is suppressed and logged.
    drive(1'b1, BASE + 32'h04, 4'b0011, 32'h7, 32'b0);
    #1;
    check("pw_ce", {28'b0, periph_ce}, 32'h0);
    check("pw_we", {31'b0, periph_we}, 32'h0);
    step("pw_ret");
    drive(1'b1, BASE + 32'hFF0, 4'b0000, 32'b0, 32'd1);
    step("st_cnt1");
    drive(1'b1, BASE + 32'hFF4, 4'b0000, 32'b0, BASE + 32'h04);
    step("st_addr1");
    drive(1'b1, BASE + 32'hFF8, 4'b0000, 32'b0, 32'b0);
    step("st_ff8");

    // Clear, then an unmapped slot read.
    drive(1'b1, BASE + 32'hFF0, 4'b1111, 32'b0, 32'b0);
    step("clr_ret");
    drive(1'b1, BASE + 32'hFF0, 4'b0000, 32'b0, 32'b0);
    step("st_cleared");
    drive(1'b1, BASE + 32'h40, 4'b0000, 32'b0, 32'b0);
    #1;
    check("um_ce", {28'b0, periph_ce}, 32'h0);
    check("um_dmem_we", {28'b0, dmem_we}, 32'h0);
    step("um_ret");
    drive(1'b1, BASE + 32'hFF4, 4'b1111, 32'hFFFF_FFFF, 32'b0);
    step("wr_ff4_ret");
    drive(1'b1, BASE + 32'hFF0, 4'b0000, 32'b0, 32'd1);
    step("st_cnt_um");
    drive(1'b1, BASE + 32'hFF4, 4'b0000, 32'b0, BASE + 32'h40);
    step("st_addr_um");
    drive(1'b1, BASE + 32'h30, 4'b0000, 32'b0, SLOT3);
    #1;
    check("rd3_ce", {28'b0, periph_ce}, 32'h8);
    step("rd3_ret");

    // Drive the counter to saturation with unmapped accesses, then one more.
    for (int i = 0; i < 65534; i++) begin
      dvalid = 1'b1;
      daddr  = BASE + 32'h800;
      dwe    = 4'b0000;
      @(posedge clk);
      #1;
    end
    drive(1'b1, BASE + 32'hFF0, 4'b0000, 32'b0, 32'h0000_FFFF);
    step("sat_full");
    drive(1'b1, BASE + 32'h500, 4'b1111, 32'b0, 32'b0);
    step("sat_err_ret");
    drive(1'b1, BASE + 32'hFF0, 4'b0000, 32'b0, 32'h0000_FFFF);
    step("sat_hold");
    drive(1'b1, BASE + 32'hFF4, 4'b0000, 32'b0, BASE + 32'h500);
    step("sat_addr");

    // Reset pulse between a read and its return discards the return.
    drive(1'b1, 32'h0000_0300, 4'b0000, 32'b0, MEMD);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    dvalid  = 1'b0;
    #1;
    check("rstmid_drdata", drdata, 32'b0);
    exp_q.delete();
    #1;
    reset_n = 1'b1;
    #1;
    check("rstpost_drdata", drdata, 32'b0);
    drive(1'b1, BASE + 32'hFF0, 4'b0000, 32'b0, 32'b0);
    step("rst_cnt");
    drive(1'b1, BASE + 32'hFF4, 4'b0000, 32'b0, 32'b0);
    step("rst_addr");
    drive(1'b0, 32'b0, 4'b0000, 32'b0, 32'b0);
    step("idle_ret");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Data-side address decoder and read-return arbiter between the CPU data port, data memory, and up to `NPERIPH` 16-byte memory-mapped peripherals. It generates each peripheral's `ce`, collapses the CPU's 4-bit byte-write strobe into a 1-bit `we`, and forwards `addr`/`wdata`. It also steers the one-cycle-latency read data from memory, the peripherals and its own status registers back onto `drdata`. Illegal accesses (unmapped slot, partial-word peripheral write) are suppressed, counted, and logged.

## Interface
- `NPERIPH`, 4 — number of peripheral slots (1..16)
- `PERIPH_BASE`, 32'h8000_0000 — 4 KB-aligned base of the peripheral window
- `clk`  in  1  — clock; everything is on the rising edge
- `reset_n`  in  1  — asynchronous, active-low reset
- `dvalid`  in  1  — CPU performs a data access this cycle
- `daddr`  in  32  — CPU data byte address
- `dwe`  in  4  — CPU byte write strobes; 4'b0000 means read
- `dwdata`  in  32  — CPU write data
- `drdata`  out  32  — read data, valid the cycle after the access
- `dmem_we`  out  4  — byte strobes to data memory
- `dmem_rdata`  in  32  — data memory read data (1-cycle latency)
- `periph_ce`  out  NPERIPH  — one-hot peripheral select
- `periph_we`  out  1  — peripheral write enable
- `periph_addr`  out  2  — `daddr[3:2]`
- `periph_wdata`  out  32  — `dwdata`, passed through
- `periph_rdata`  in  32*NPERIPH  — flattened peripheral read data; slot k is at `[32k+31:32k]`, 1-cycle latency

## Operation
- Window hit (`win`): `daddr[31:12] == PERIPH_BASE[31:12]`.
- Slot index: `idx = daddr[7:4]`.
- Status block: `win && daddr[11:4] == 8'hFF`.
- Peripheral hit: `win && daddr[11:8] == 0 && idx < NPERIPH`.
- Any other in-window address is unmapped.
- Decode is combinational and qualified by `dvalid`.
- **Memory access** (`!win`): `dmem_we = dwe`; no `ce` asserted. When `win` or `!dvalid`, `dmem_we = 0`.
- **Peripheral access:**
  - `periph_ce[idx] = 1`.
  - `periph_we = (dwe == 4'b1111)`.
  - Any other non-zero `dwe` is a partial write: `ce` is forced to 0 and an error is raised.
- **Status registers** (read data registered internally):
  - base+0xFF0 reads `{16'b0, err_count}`.
  - base+0xFF4 reads `last_err_addr`.
  - Any write (any non-zero `dwe`) to +0xFF0 clears both registers.
  - Writes to +0xFF4, and to +0xFF8/+0xFFC, are ignored without error; reads of +0xFF8/+0xFFC return 0.
- **Unmapped access:** no `ce`, no memory write; raises an error; read returns 0.
- **Error event:**
  - `err_count` increments and saturates at 16'hFFFF.
  - `last_err_addr <= daddr`.
- **Return select:** `sel_q` is registered each cycle and takes one of these values:
  - NONE, when `!dvalid`, on any write, or on an unmapped/partial access.
  - MEM, PERIPH(k) or STATUS, for a read.
- **Read-data mux:** `drdata` is combinational from `sel_q`:
  - MEM → `dmem_rdata`
  - PERIPH(k) → slot k of `periph_rdata`
  - STATUS → internal status data register
  - NONE → 0
- **Reset** (`reset_n` low, asynchronous):
  - `sel_q` = NONE.
  - `err_count`, `last_err_addr` and the status data register = 0.
  - `drdata` = 0.
  - Combinational outputs follow the inputs.

## Timing
- Cycle N: decode outputs valid combinationally; peripheral/memory samples at edge N.
- Cycle N+1: `drdata` carries the data for the read issued in cycle N. Back-to-back reads to different targets each return in their own next cycle; no bubbles.
- Error counter and `last_err_addr` update at the edge ending the offending cycle; a status read in N+1 sees the new value.
- Clear write in cycle N: a status read in N+1 returns 0.
- A reset asserted mid-access discards any pending return: the first cycle after release reads 0.

## Test plan
- Write 4'b1111 with `dwdata` 5 to base+0x14 (slot 1, addr 1) → `periph_ce = 4'b0010`, `periph_we = 1`, `periph_addr = 1`, `dmem_we = 0`.
- Read base+0x18, slot 1 returns 32'h1234 next cycle; then read 0x100 with `dmem_rdata` 32'hAA → `drdata` 32'h1234 then 32'hAA on consecutive cycles.
- Write `dwe` 4'b0011 to base+0x04 → all `ce` low; then read base+0xFF0 → 1; read base+0xFF4 → 32'h8000_0004.
- Read base+0x40 with `NPERIPH` = 4 → `drdata` 0; `err_count` 1.
- Force `err_count` to 16'hFFFF, raise one more error → count stays 16'hFFFF.
- Write base+0xFF0 → next status read returns 0.
- Pulse `reset_n` low between a read and its return cycle → `drdata` 0 and the counters cleared immediately.
